// File: rtl/flow_extreme_rmw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : flow_extreme_rmw_pkg                                   |
// | Description : TFE shared package: flow-id width default, table depth,|
// |               extreme selector encoding for the min/max ALU.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package flow_extreme_rmw_pkg;

   localparam int TFE_FLOW_AW = 6;
   localparam int TFE_DATA_W  = 8;
   localparam int TFE_DEPTH   = 1 << TFE_FLOW_AW;

   // Extreme selector driven to the external ALU
   typedef enum logic {
      TFE_FUNC_MIN = 1'b0,
      TFE_FUNC_MAX = 1'b1
   } tfe_func_e;

   // Table depth for an arbitrary flow-id width
   function automatic int tfe_depth(input int aw);
      return 1 << aw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/flow_hist_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : flow_hist_ram                                          |
// | Description : Per-flow history data memory, one write port and one  |
// |               synchronous read port. Contents are not reset.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module flow_hist_ram
   import flow_extreme_rmw_pkg::*;
#(
   parameter int AW = TFE_FLOW_AW,
   parameter int DW = TFE_DATA_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int DEPTH = tfe_depth(AW);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // Write port and registered read; a same-address read returns old data
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/flow_extreme_rmw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : flow_extreme_rmw                                       |
// | Description : Per-flow running min/max read-modify-write pipeline.   |
// |               S0 reads the table, S1 drives the external ALU, S2     |
// |               writes the ALU result back and reports it.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module flow_extreme_rmw
   import flow_extreme_rmw_pkg::*;
#(
   parameter tfe_func_e FUNC    = TFE_FUNC_MAX,
   parameter int        FLOW_AW = TFE_FLOW_AW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pkt_v,
   input  logic [FLOW_AW-1:0] pkt_flow_id,
   input  logic [7:0]         pkt_data,
   input  logic               clr_v,
   input  logic [FLOW_AW-1:0] clr_flow_id,
   output logic               clr_ready,
   output logic [7:0]         alu_hist_data,
   output logic               alu_hist_v,
   output logic [7:0]         alu_cur_data,
   output logic               alu_cur_v,
   output logic               alu_func,
   input  logic [7:0]         alu_ext_data,
   input  logic               alu_ext_v,
   output logic               feat_v,
   output logic [FLOW_AW-1:0] feat_flow_id,
   output logic [7:0]         feat_data,
   output logic               err_collide
);

   localparam int DEPTH = tfe_depth(FLOW_AW);

   logic [DEPTH-1:0]   valid_q, valid_d;
   logic               s1_v_q, s1_v_d;
   logic [FLOW_AW-1:0] s1_flow_q, s1_flow_d;
   logic [7:0]         s1_data_q, s1_data_d;
   logic               s2_v_q, s2_v_d;
   logic [FLOW_AW-1:0] s2_flow_q, s2_flow_d;
   logic               wb_v_q, wb_v_d;
   logic [FLOW_AW-1:0] wb_flow_q, wb_flow_d;
   logic [7:0]         wb_data_q, wb_data_d;
   logic               err_q, err_d;

   logic               pkt_acc;
   logic               clr_rdy;
   logic               clr_acc;
   logic               wr_en;
   logic               fwd_a;
   logic               fwd_b;
   logic               hist_sel_v;
   logic [7:0]         hist_sel;
   logic [7:0]         rd_data;

   flow_hist_ram #(
      .AW (FLOW_AW),
      .DW (8)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (s2_flow_q),
      .wdata (alu_ext_data),
      .raddr (pkt_flow_id),
      .rdata (rd_data)
   );

   // Next-state: stage advance, write-back capture, valid bits, sticky error
   always_comb begin
      pkt_acc   = pkt_v & ~clr_v;
      clr_rdy   = ~s1_v_q & ~s2_v_q & ~pkt_v;
      clr_acc   = clr_v & clr_rdy;
      wr_en     = s2_v_q & alu_ext_v;

      s1_v_d    = pkt_acc;
      s1_flow_d = pkt_flow_id;
      s1_data_d = pkt_data;
      s2_v_d    = s1_v_q;
      s2_flow_d = s1_flow_q;
      wb_v_d    = wr_en;
      wb_flow_d = s2_flow_q;
      wb_data_d = alu_ext_data;

      valid_d = valid_q;
      if (wr_en) begin
         valid_d[s2_flow_q] = 1'b1;
      end
      if (clr_acc) begin
         valid_d[clr_flow_id] = 1'b0;
      end

      err_d = err_q | (pkt_v & clr_v) | (s2_v_q & ~alu_ext_v);
   end

   // History source for S1: in-flight S2 result, then last write-back, then table
   always_comb begin
      fwd_a      = wr_en & (s2_flow_q == s1_flow_q);
      fwd_b      = wb_v_q & (wb_flow_q == s1_flow_q);
      hist_sel   = rd_data;
      hist_sel_v = valid_q[s1_flow_q];
      if (fwd_a) begin
         hist_sel   = alu_ext_data;
         hist_sel_v = 1'b1;
      end else if (fwd_b) begin
         hist_sel   = wb_data_q;
         hist_sel_v = 1'b1;
      end
   end

   // Pipeline and table-state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= '0;
         s1_v_q    <= 1'b0;
         s1_flow_q <= '0;
         s1_data_q <= '0;
         s2_v_q    <= 1'b0;
         s2_flow_q <= '0;
         wb_v_q    <= 1'b0;
         wb_flow_q <= '0;
         wb_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         s1_v_q    <= s1_v_d;
         s1_flow_q <= s1_flow_d;
         s1_data_q <= s1_data_d;
         s2_v_q    <= s2_v_d;
         s2_flow_q <= s2_flow_d;
         wb_v_q    <= wb_v_d;
         wb_flow_q <= wb_flow_d;
         wb_data_q <= wb_data_d;
         err_q     <= err_d;
      end
   end

   assign clr_ready     = clr_rdy;
   assign alu_func      = FUNC;
   assign alu_cur_v     = s1_v_q;
   assign alu_cur_data  = s1_v_q ? s1_data_q : 8'h00;
   assign alu_hist_v    = s1_v_q & hist_sel_v;
   assign alu_hist_data = (s1_v_q & hist_sel_v) ? hist_sel : 8'h00;
   assign feat_v        = wr_en;
   assign feat_flow_id  = wr_en ? s2_flow_q : '0;
   assign feat_data     = wr_en ? alu_ext_data : 8'h00;
   assign err_collide   = err_q;

endmodule
`default_nettype wire

// File: doc/flow_extreme_rmw.md
FLOW_EXTREME_RMW -- requirements
Module: flow_extreme_rmw

Interface
REQ-001 SHALL have parameter FUNC, default 1, extreme selector driven to the ALU (0 min, 1 max).
REQ-002 SHALL have parameter FLOW_AW, default 6, flow-id width (64 flows).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pkt_v  input  1  packet feature valid, one per cycle, no backpressure.
REQ-006 pkt_flow_id  input  FLOW_AW  flow index of packet.
REQ-007 pkt_data  input  8  per-packet feature value (e.g. length byte).
REQ-008 clr_v  input  1  clear request for one flow's history.
REQ-009 clr_flow_id  input  FLOW_AW  flow to clear.
REQ-010 clr_ready  output  1  high when the pipeline is empty and a clear is accepted.
REQ-011 alu_hist_data / alu_hist_v  output  8 / 1  stored extreme and its valid, to the min/max ALU.
REQ-012 alu_cur_data / alu_cur_v  output  8 / 1  current packet value and valid, to the ALU.
REQ-013 alu_func  output  1  constant FUNC.
REQ-014 alu_ext_data / alu_ext_v  input  8 / 1  registered ALU result, valid one cycle after alu_cur_v.
REQ-015 feat_v / feat_flow_id / feat_data  output  1 / FLOW_AW / 8  updated extreme per packet.
REQ-016 err_collide  output  1  sticky, set when pkt_v and clr_v are both high.

Function
REQ-017 Pipeline: S0 (cycle t) accepts pkt_v and issues a synchronous table read; S1 (t+1) drives the ALU; S2 (t+2) captures alu_ext_*, writes the table and asserts feat_v. Latency pkt_v to feat_v is exactly 2 cycles.
REQ-018 Table: 2^FLOW_AW x 8 data memory with synchronous read; per-flow valid bits held in flops.
REQ-019 In S1, alu_cur_v=1, alu_cur_data=S1 packet data, alu_hist_v=flow valid bit, alu_hist_data=stored value; outside S1 ops, alu_cur_v=0 and alu_hist_v=0.
REQ-020 Forward A: if S1 flow equals S2 flow (packets 1 cycle apart), hist = alu_ext_data and hist_v=1.
REQ-021 Forward B: if S1 flow equals the flow written in the previous cycle (packets 2 cycles apart), hist = that write-back value and hist_v=1.
REQ-022 When both forwards match, Forward A (younger) wins; neither matching uses the table read.
REQ-023 S2 write sets the flow valid bit and stores alu_ext_data; feat_flow_id/feat_data reflect the same values in that cycle.
REQ-024 alu_ext_v low while an S2 op is present SHALL set err_collide and skip the write.
REQ-025 clr_ready = no op in S1 or S2 and pkt_v low; an accepted clear drops the flow valid bit at the next edge; clr_v without clr_ready is ignored.
REQ-026 pkt_v and clr_v high together: the packet is dropped, no clear occurs, and err_collide is set.
REQ-027 The block adds no arithmetic; all comparison is in the ALU; flow ids compare on all FLOW_AW bits.

Reset
REQ-028 rst_n low SHALL clear all flow valid bits, stage valids, feat_* , alu_* outputs and err_collide to 0 asynchronously; data memory contents are don't-care.
REQ-029 Reset mid-operation SHALL discard in-flight ops with no write; the first post-reset packet of any flow sees hist_v=0.

Structure
REQ-030 FLOW_AW default, the table depth and the FUNC encoding (0 min, 1 max) SHALL live in the shared TFE package.
REQ-031 The data memory SHALL be one sub-module, flow_hist_ram (1 write, 1 sync read port); the ALU stays external.

Verification
REQ-032 Reset, then FUNC=1, flow 3 gets 40, 90, 20 spaced 5 cycles -> feat_data 40, 90, 90; first alu_hist_v=0.
REQ-033 FUNC=1, flow 5 back-to-back 10, 50, 30 -> feat_data 10, 50, 50 via Forward A; table holds 50.
REQ-034 FUNC=0, flow 7 gets 60, idle, 25 (2 apart) -> Forward B gives hist 60, feat_data 25.
REQ-035 Interleaved flows 1,2,1 with 9, 200, 4 (FUNC=0) -> flow1 extreme 4, flow2 200, no cross-flow forward.
REQ-036 Flow 8 holds 77; idle, clear 8 (clr_ready=1), then packet 12 -> alu_hist_v=0, feat_data 12.
REQ-037 pkt_v and clr_v same cycle -> err_collide=1 and stays 1; rst_n pulse mid-stream -> no feat_v for in-flight packets.
